lsu_mem_if: RTL and testbench

Load/store interface unit sitting directly downstream of the multicycle control FSM and datapath, between the CPU memory-access state and the unified instruction/data SPRAM. It accepts one access request at a time (funct3-encoded width/sign), generates word address, byte enables and lane-replicated write data, and waits on a variable-latency memory ack with timeout. It returns sign/zero-extended load data plus a ready pulse the FSM uses to leave its memory state.

---
 rtl/lsu_mem_if_if.sv | 32 +++
 rtl/lsu_mem_if.sv | 202 ++++++++++++++++++++
 tb/tb_lsu_mem_if.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_if_if.sv
// Bundle of the CPU-side access handshake and the SPRAM port of the load/store unit.
// The slave modport is the LSU itself; the master modport drives it (CPU FSM plus memory model).
interface lsu_mem_if_if #(
    parameter int MEM_AW = 12
) ();
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;
    logic              err;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport slave (
        input  req, we, funct3, addr, wdata, mem_rdata, mem_ack,
        output rdata, ready, err, busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req, we, funct3, addr, wdata, mem_rdata, mem_ack,
        input  rdata, ready, err, busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_if.sv
// Load/store unit between the multicycle CPU memory state and the unified SPRAM:
// one access at a time, lane steering, load extension, ack timeout.
module lsu_mem_if #(
    parameter int MEM_AW  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    lsu_mem_if_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lane_q, lane_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              illegal;
    logic              misaligned;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;
    logic [31:0]       shifted;
    logic [31:0]       load_ext;

    // Address bits above the memory size alias onto the same words.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:MEM_AW+2];

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = bus.wdata;
        case (bus.funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = bus.we;
            default:                illegal = 1'b1;
        endcase
        case (bus.funct3[1:0])
            2'b01:   misaligned = bus.addr[0];
            2'b10:   misaligned = (bus.addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (bus.we) begin
            case (bus.funct3[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << bus.addr[1:0];
                    wdata_new = {4{bus.wdata[7:0]}};
                end
                2'b01: begin
                    be_new    = 4'b0011 << {bus.addr[1], 1'b0};
                    wdata_new = {2{bus.wdata[15:0]}};
                end
                default: begin
                    be_new    = 4'b1111;
                    wdata_new = bus.wdata;
                end
            endcase
        end
    end

    always_comb begin
        shifted  = bus.mem_rdata >> {lane_q, 3'b000};
        load_ext = bus.mem_rdata;
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'b0, shifted[7:0]};
            3'b101:  load_ext = {16'b0, shifted[15:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // NOTE: every next-state signal gets its hold value first so no path through the
    // case leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        err_d       = err_q;
        busy_d      = busy_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    busy_d = 1'b1;
                    we_d   = bus.we;
                    f3_d   = bus.funct3;
                    lane_d = bus.addr[1:0];
                    if (illegal || misaligned) begin
                        state_d = S_DONE;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.we;
                        mem_addr_d  = bus.addr[MEM_AW+1:2];
                        mem_be_d    = be_new;
                        mem_wdata_d = wdata_new;
                        cnt_d       = 8'd0;
                    end
                end
            end
            S_ACCESS: begin
                if (bus.mem_ack) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = 1'b0;
                    if (!we_q) rdata_d = load_ext;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: registers are updated with non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            lane_q      <= 2'b00;
            cnt_q       <= 8'd0;
            rdata_q     <= 32'd0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: stores, extended loads, errors, timeout, reset abort.
module tb_lsu_mem_if;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    lsu_mem_if_if #(.MEM_AW(12)) bus ();

    lsu_mem_if #(.MEM_AW(12), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access; ack_delay = mem_req cycles before ack (-1 = never). Returns what it saw.
    task automatic xfer(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_delay, input logic [31:0] mrd,
                        output int lat, output int req_cycles, output logic e,
                        output logic [3:0] be, output logic [31:0] mwd,
                        output logic [11:0] ma, output logic mwe, output logic stable);
        logic busy_ok;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        @(negedge clk);
        bus.req = 1'b0;
        lat = 1; req_cycles = 0; stable = 1'b1; busy_ok = 1'b1;
        be = 4'h0; mwd = 32'h0; ma = 12'h0; mwe = 1'b0;
        while (bus.ready !== 1'b1 && lat < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.mem_req === 1'b1) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    be = bus.mem_be; mwd = bus.mem_wdata; ma = bus.mem_addr; mwe = bus.mem_we;
                end else if (bus.mem_be !== be || bus.mem_wdata !== mwd ||
                             bus.mem_addr !== ma || bus.mem_we !== mwe) begin
                    stable = 1'b0;
                end
                if (req_cycles - 1 == ack_delay) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = mrd;
                end
            end
            @(negedge clk);
            bus.mem_ack = 1'b0;
            lat++;
        end
        e = bus.err;
        check("busy_during", {31'b0, busy_ok & bus.busy}, 32'd1);
        check("memreq_at_ready", {31'b0, bus.mem_req}, 32'd0);
        @(negedge clk);
        check("ready_one_cycle", {30'b0, bus.ready, bus.busy}, 32'd0);
    endtask

    int          lat, rc, n_ready, n_req;
    logic        e, mwe, st;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [11:0] ma;

    initial begin
        checks = 0; errors = 0;
        bus.req = 0; bus.we = 0; bus.funct3 = 0; bus.addr = 0; bus.wdata = 0;
        bus.mem_rdata = 0; bus.mem_ack = 0;
        reset = 1'b1;
        #23;
        check("rst_outs", {bus.rdata[0], bus.ready, bus.err, bus.busy, bus.mem_req, bus.mem_we}, 32'd0);
        check("rst_bus", {16'b0, bus.mem_addr, bus.mem_be}, 32'd0);
        check("rst_wdata", bus.mem_wdata | bus.rdata, 32'd0);
        @(negedge clk); reset = 1'b0;

        // sw 0x10
        xfer(1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, lat, rc, e, be, mwd, ma, mwe, st);
        check("sw_lat", lat, 2);
        check("sw_addr", {20'b0, ma}, 32'd4);
        check("sw_be", {28'b0, be}, 32'hF);
        check("sw_wdata", mwd, 32'hDEAD_BEEF);
        check("sw_we_err", {30'b0, mwe, e}, 32'b10);

        // loads from one word 0x80FF1234
        xfer(0, 3'b000, 32'h13, 0, 0, 32'h80FF_1234, lat, rc, e, be, mwd, ma, mwe, st);
        check("lb_be_we", {27'b0, be, mwe}, {27'b0, 4'hF, 1'b0});
        check("lb_rdata", bus.rdata, 32'hFFFF_FF80);
        xfer(0, 3'b100, 32'h13, 0, 0, 32'h80FF_1234, lat, rc, e, be, mwd, ma, mwe, st);
        check("lbu_rdata", bus.rdata, 32'h0000_0080);
        xfer(0, 3'b001, 32'h12, 0, 0, 32'h80FF_1234, lat, rc, e, be, mwd, ma, mwe, st);
        check("lh_rdata", bus.rdata, 32'hFFFF_80FF);
        xfer(0, 3'b101, 32'h12, 0, 0, 32'h80FF_1234, lat, rc, e, be, mwd, ma, mwe, st);
        check("lhu_rdata", bus.rdata, 32'h0000_80FF);
        xfer(0, 3'b010, 32'h14, 0, 0, 32'h80FF_1234, lat, rc, e, be, mwd, ma, mwe, st);
        check("lw_rdata", bus.rdata, 32'h80FF_1234);
        check("lw_addr_err", {19'b0, ma, e}, {19'b0, 12'd5, 1'b0});

        // sb with delayed ack
        xfer(1, 3'b000, 32'h21, 32'h0000_00AB, 5, 32'h0, lat, rc, e, be, mwd, ma, mwe, st);
        check("sb_be", {28'b0, be}, 32'b0010);
        check("sb_wdata", mwd, 32'hABAB_ABAB);
        check("sb_req_cycles", rc, 6);
        check("sb_stable", {31'b0, st}, 32'd1);
        check("sb_lat_err", {lat[30:0], e}, {31'd7, 1'b0});
        check("sb_rdata_keep", bus.rdata, 32'h80FF_1234);

        // sh upper half
        xfer(1, 3'b001, 32'h22, 32'h1234_CAFE, 1, 32'h0, lat, rc, e, be, mwd, ma, mwe, st);
        check("sh_be", {28'b0, be}, 32'b1100);
        check("sh_wdata", mwd, 32'hCAFE_CAFE);

        // errors with no memory cycle
        xfer(0, 3'b010, 32'h06, 0, 0, 32'h5555_5555, lat, rc, e, be, mwd, ma, mwe, st);
        check("mis_lw", {lat[15:0], rc[14:0], e}, {16'd1, 15'd0, 1'b1});
        check("mis_rdata_keep", bus.rdata, 32'h80FF_1234);
        xfer(0, 3'b011, 32'h00, 0, 0, 32'h5555_5555, lat, rc, e, be, mwd, ma, mwe, st);
        check("ill_f3_011", {lat[15:0], rc[14:0], e}, {16'd1, 15'd0, 1'b1});
        xfer(1, 3'b100, 32'h00, 0, 0, 32'h5555_5555, lat, rc, e, be, mwd, ma, mwe, st);
        check("ill_store_u", {lat[15:0], rc[14:0], e}, {16'd1, 15'd0, 1'b1});
        xfer(0, 3'b001, 32'h11, 0, 0, 32'h5555_5555, lat, rc, e, be, mwd, ma, mwe, st);
        check("mis_lh", {lat[15:0], rc[14:0], e}, {16'd1, 15'd0, 1'b1});

        // timeout, then normal access
        xfer(0, 3'b010, 32'h30, 0, -1, 32'h0, lat, rc, e, be, mwd, ma, mwe, st);
        check("to_req_cycles", rc, 15);
        check("to_lat_err", {lat[30:0], e}, {31'd16, 1'b1});
        check("to_rdata_keep", bus.rdata, 32'h80FF_1234);
        xfer(0, 3'b010, 32'h30, 0, 0, 32'hCAFE_F00D, lat, rc, e, be, mwd, ma, mwe, st);
        check("after_to", bus.rdata, 32'hCAFE_F00D);

        // upper address bits wrap
        xfer(0, 3'b010, 32'hFFFF_C008, 0, 0, 32'h0BAD_F00D, lat, rc, e, be, mwd, ma, mwe, st);
        check("wrap_addr", {20'b0, ma}, 32'h002);

        // second req during busy is ignored
        @(negedge clk);
        bus.req = 1'b1; bus.we = 0; bus.funct3 = 3'b010; bus.addr = 32'h80;
        @(negedge clk);
        check("busy2_memreq", {31'b0, bus.mem_req}, 32'd1);
        bus.addr = 32'h84;
        @(negedge clk);
        bus.req = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1122_3344;
        n_ready = 0; n_req = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.ready === 1'b1) n_ready++;
            if (bus.mem_req === 1'b1) n_req++;
        end
        check("busy2_ready_cnt", n_ready, 1);
        check("busy2_no_req", n_req, 0);
        check("busy2_rdata", bus.rdata, 32'h1122_3344);

        // reset mid-access
        @(negedge clk);
        bus.req = 1'b1; bus.we = 0; bus.funct3 = 3'b010; bus.addr = 32'h40;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("rst_mid_pre", {30'b0, bus.mem_req, bus.busy}, 32'b11);
        #2 reset = 1'b1;
        #1 check("rst_mid_async", {30'b0, bus.mem_req, bus.busy}, 32'b00);
        @(negedge clk); reset = 1'b0;
        n_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) n_ready++;
        end
        check("rst_mid_no_ready", n_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
